ntt_pipe_ctrl: RTL and testbench
================================

// Module: ntt_pipe_ctrl
// PURPOSE
//  Sequencer for one Kyber NTT/INTT pipeline pass over 128 coefficient pairs (one 256-coeff polynomial).
//  Accepts a start command and the pair stream handshake, then drives the shared pipeline enable, the mode
//  and the final-stage twiddle ROM address. Tracks fill latency and flags valid pairs at the pipeline output.
//  Sits between the top-level polynomial loader/storer and the butterfly pipeline (stages + end stage).
// PARAMETERS
//  NPAIRS     128  butterfly pairs per pass
//  FILL_LAT   104  enabled cycles from pair entering pipe to NTT output (7*6+32+16+8+4+2)
//  INTT_EXTRA 4    extra enabled cycles in INTT mode (output reg + 3303 scaling modmul)
//  TW_BASE    64   first final-stage twiddle address in NTT mode; wraps 127->TW_BASE
//  TW_INTT    1    constant final-stage twiddle address in INTT mode
//  AW         7    twiddle ROM address width
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   begin pass; sampled only in IDLE
//  mode       in   1   0=NTT, 1=INTT; latched with start
//  in_valid   in   1   input pair present on pipeline inputs
//  in_ready   out  1   controller accepts a pair this cycle
//  pipe_en    out  1   enable to every pipeline stage (combinational from state/in_valid)
//  pipe_mode  out  1   latched mode to pipeline
//  tw_addr    out  AW  final-stage twiddle ROM read address
//  out_valid  out  1   pipeline output pair valid this cycle
//  out_idx    out  7   index (0..NPAIRS-1) of pair at output when out_valid
//  busy       out  1   pass in progress (state != IDLE)
//  done       out  1   one-cycle pulse after last output pair
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, pipe_en=0, pipe_mode=0, tw_addr=TW_BASE, out_valid=0, out_idx=0, busy=0, done=0.
//   Internal in_cnt, out_cnt, en_cnt = 0. Reset mid-pass aborts immediately; no residual outputs.
//  States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches mode into pipe_mode, clears counters, sets tw_addr = mode?TW_INTT:TW_BASE, goes RUN.
//  RUN: in_ready=1; pipe_en=in_valid (pipe freezes when in_valid=0, no bubbles). Each accepted pair
//   increments in_cnt; the accept with in_cnt==NPAIRS-1 moves to DRAIN.
//  DRAIN: in_ready=0, pipe_en=1 every cycle; in_valid ignored.
//  en_cnt (9b) increments on every pipe_en cycle; LAT = FILL_LAT (+INTT_EXTRA if pipe_mode=1).
//  out_valid = pipe_en & (en_cnt >= LAT) & (out_cnt < NPAIRS); out_idx = out_cnt; out_cnt++ on out_valid.
//  When out_valid with out_cnt==NPAIRS-1: next state DONE. DONE: done=1 for one cycle, pipe_en=0, -> IDLE.
//  Twiddle (NTT): tw_addr holds TW_BASE until en_cnt reaches FILL_LAT; thereafter increments on each pipe_en
//   cycle, 127 -> TW_BASE wrap. Frozen whenever pipe_en=0. INTT: tw_addr constant TW_INTT whole pass.
//  start while busy ignored; mode changes after latch ignored. pipe_mode holds last pass value in IDLE.
//  Max en_cnt = NPAIRS+LAT <= 236; no overflow in 9b.
//  Pipe output is not back-pressured; consumer must take every out_valid pair.
// TESTING
//  1 NTT, in_valid=1 continuously: out_valid first at enabled cycle 104 (out_idx 0), 128 contiguous, done 1 cycle
//    after out_idx 127; total start->done = 1+128+104+1 cycles.
//  2 INTT continuous: first out_valid at enabled cycle 108; tw_addr==1 throughout; pipe_mode==1.
//  3 NTT with in_valid low 1 of every 3 cycles in RUN: pipe_en/tw_addr frozen on gaps; out_idx still 0..127 gapless.
//  4 tw_addr wrap: NTT continuous, tw_addr 64 until en_cnt 104, then 65..127,64,65..; check 127->64 step.
//  5 start pulsed mid-pass, mode toggled: ignored, pass completes unchanged; start in DONE cycle ignored.
//  6 rst asserted at en_cnt=50: all outputs to reset values same cycle; new start after release runs clean pass.

Source files
------------

// File: rtl/ntt_pipe_ctrl_if.sv
// Command, handshake and pipeline-control bundle between the polynomial
// loader/storer and the NTT pipeline sequencer.
interface ntt_pipe_ctrl_if #(
    parameter int unsigned AW = 7
);
    logic          start;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic          pipe_en;
    logic          pipe_mode;
    logic [AW-1:0] tw_addr;
    logic          out_valid;
    logic [6:0]    out_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, mode, in_valid,
        input  in_ready, pipe_en, pipe_mode, tw_addr, out_valid, out_idx, busy, done
    );

    modport slave (
        input  start, mode, in_valid,
        output in_ready, pipe_en, pipe_mode, tw_addr, out_valid, out_idx, busy, done
    );
endinterface

// File: rtl/ntt_pipe_ctrl.sv
// Sequencer for one Kyber NTT/INTT pass over 128 coefficient pairs: drives the shared
// pipeline enable, mode and final-stage twiddle address, and marks valid output pairs.
module ntt_pipe_ctrl #(
    parameter int unsigned NPAIRS     = 128,
    parameter int unsigned FILL_LAT   = 104,
    parameter int unsigned INTT_EXTRA = 4,
    parameter int unsigned TW_BASE    = 64,
    parameter int unsigned TW_INTT    = 1,
    parameter int unsigned AW         = 7
) (
    input  logic           clk,
    input  logic           rst,
    ntt_pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    localparam logic [6:0]    LAST_IN   = 7'(NPAIRS - 1);
    localparam logic [7:0]    LAST_OUT  = 8'(NPAIRS - 1);
    localparam logic [7:0]    NPAIRS_C  = 8'(NPAIRS);
    localparam logic [8:0]    LAT_NTT   = 9'(FILL_LAT);
    localparam logic [8:0]    LAT_INTT  = 9'(FILL_LAT + INTT_EXTRA);
    localparam logic [AW-1:0] TW_BASE_C = AW'(TW_BASE);
    localparam logic [AW-1:0] TW_INTT_C = AW'(TW_INTT);
    localparam logic [AW-1:0] TW_LAST   = '1;

    state_e        state_q, state_d;
    logic [6:0]    in_cnt_q, in_cnt_d;
    logic [7:0]    out_cnt_q, out_cnt_d;
    logic [8:0]    en_cnt_q, en_cnt_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] tw_q, tw_d;
    logic          pipe_en;
    logic          out_valid;
    logic [8:0]    lat;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            en_cnt_q  <= '0;
            mode_q    <= 1'b0;
            tw_q      <= TW_BASE_C;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            en_cnt_q  <= en_cnt_d;
            mode_q    <= mode_d;
            tw_q      <= tw_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        en_cnt_d  = en_cnt_q;
        mode_d    = mode_q;
        tw_d      = tw_q;

        lat       = mode_q ? LAT_INTT : LAT_NTT;
        pipe_en   = ((state_q == S_RUN) && bus.in_valid) || (state_q == S_DRAIN);
        out_valid = pipe_en && (en_cnt_q >= lat) && (out_cnt_q < NPAIRS_C);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    en_cnt_d  = '0;
                    tw_d      = bus.mode ? TW_INTT_C : TW_BASE_C;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    in_cnt_d = in_cnt_q + 7'd1;
                    if (in_cnt_q == LAST_IN) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid && (out_cnt_q == LAST_OUT)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The pipe is frozen when pipe_en is low, so every counter and the twiddle freeze with it.
        if (pipe_en) begin
            en_cnt_d = en_cnt_q + 9'd1;
            if (!mode_q && (en_cnt_q >= LAT_NTT))
                tw_d = (tw_q == TW_LAST) ? TW_BASE_C : tw_q + 1'b1;
            if (out_valid) out_cnt_d = out_cnt_q + 8'd1;
        end
    end

    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.pipe_en   = pipe_en;
    assign bus.pipe_mode = mode_q;
    assign bus.tw_addr   = tw_q;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_cnt_q[6:0];
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_ntt_pipe_ctrl.sv
// Directed bench for ntt_pipe_ctrl: NTT/INTT passes, input gaps, twiddle wrap,
// ignored start/mode during a pass, and asynchronous reset mid-pass.
module tb_ntt_pipe_ctrl;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] tw_seen [0:255];

    ntt_pipe_ctrl_if #(.AW(7)) bus ();

    ntt_pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one pass from IDLE, comparing every cycle against a small reference model.
    // gap>0 drops in_valid on every gap-th RUN cycle; poke toggles mode and pulses
    // start mid-pass and in the DONE cycle.
    task automatic run_pass(input logic m, input int gap, input bit poke, input string tag,
                            output int done_idx, output int first_out_en,
                            output int n_out, output int errs);
        int   m_in, m_out, m_en, m_tw, lat, obs_en, k;
        logic iv, exp_run, exp_drain, exp_done, exp_pe, exp_ov, bad;
        for (int i = 0; i < 256; i++) tw_seen[i] = 'x;
        done_idx = -1; first_out_en = -1; n_out = 0; errs = 0;
        m_in = 0; m_out = 0; m_en = 0; m_tw = m ? 1 : 64; obs_en = 0;
        lat = m ? 108 : 104;

        bus.start = 1'b1; bus.mode = m; bus.in_valid = 1'b1;
        #2;
        if (bus.busy !== 1'b0 || bus.pipe_en !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.done !== 1'b0 || bus.out_valid !== 1'b0) errs++;
        tick();
        bus.start = 1'b0;

        for (int idx = 1; idx < 1000; idx++) begin
            k  = idx - 1;
            iv = !(gap > 0 && (k % gap) == gap - 1);
            bus.in_valid = iv;
            exp_run   = (m_in < 128);
            exp_drain = !exp_run && (m_out < 128);
            exp_done  = (m_out == 128);
            if (poke && idx == 50) begin bus.start = 1'b1; bus.mode = ~m; end
            if (poke && idx == 51) bus.start = 1'b0;
            if (poke && exp_done)  bus.start = 1'b1;
            #2;
            exp_pe = (exp_run && iv) || exp_drain;
            exp_ov = exp_pe && (m_en >= lat) && (m_out < 128);
            bad = (bus.in_ready !== exp_run) || (bus.pipe_en !== exp_pe) ||
                  (bus.out_valid !== exp_ov) || (bus.tw_addr !== 7'(m_tw)) ||
                  (bus.done !== exp_done) || (bus.busy !== 1'b1) || (bus.pipe_mode !== m) ||
                  (exp_ov && bus.out_idx !== 7'(m_out));
            if (bad) begin
                if (errs == 0) $display("note: %s first divergence at cycle %0d", tag, idx);
                errs++;
            end
            // Observation-only bookkeeping from the DUT outputs themselves.
            if (bus.pipe_en === 1'b1) begin
                if (obs_en < 256) tw_seen[obs_en] = bus.tw_addr;
                if (bus.out_valid === 1'b1) begin
                    if (n_out == 0) first_out_en = obs_en;
                    if (bus.out_idx !== 7'(n_out)) errs++;
                    n_out++;
                end
                obs_en++;
            end
            if (bus.done === 1'b1 && done_idx < 0) done_idx = idx;
            if (exp_pe) begin
                if (exp_ov) m_out++;
                if (!m && m_en >= 104) m_tw = (m_tw == 127) ? 64 : m_tw + 1;
                m_en++;
            end
            if (exp_run && iv) m_in++;
            tick();
            if (exp_done) break;
        end
        bus.start = 1'b0;
        #2;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) errs++;
        tick();
    endtask

    initial begin
        int d, f, n, e, cnt;
        rst = 1'b1; bus.start = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0;
        #3;
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_pipe_en",   bus.pipe_en,   0);
        check("rst_pipe_mode", bus.pipe_mode, 0);
        check("rst_tw_addr",   bus.tw_addr,   64);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_idx",   bus.out_idx,   0);
        check("rst_busy",      bus.busy,      0);
        check("rst_done",      bus.done,      0);
        tick();
        rst = 1'b0;
        tick();

        // NTT, continuous input; also covers the twiddle wrap
        run_pass(1'b0, 0, 1'b0, "ntt", d, f, n, e);
        check("ntt_cycle_errs", e, 0);
        check("ntt_done_idx",   d, 233);
        check("ntt_first_out",  f, 104);
        check("ntt_n_out",      n, 128);
        check("tw_en0",   tw_seen[0],   64);
        check("tw_en103", tw_seen[103], 64);
        check("tw_en104", tw_seen[104], 64);
        check("tw_en105", tw_seen[105], 65);
        check("tw_en167", tw_seen[167], 127);
        check("tw_en168", tw_seen[168], 64);
        check("tw_en231", tw_seen[231], 127);
        check("ntt_idle_mode", bus.pipe_mode, 0);

        // INTT, continuous input
        run_pass(1'b1, 0, 1'b0, "intt", d, f, n, e);
        check("intt_cycle_errs", e, 0);
        check("intt_done_idx",   d, 237);
        check("intt_first_out",  f, 108);
        check("intt_n_out",      n, 128);
        check("intt_tw_en0",     tw_seen[0],   1);
        check("intt_tw_en235",   tw_seen[235], 1);
        check("intt_idle_mode",  bus.pipe_mode, 1);

        // NTT with in_valid low every third RUN cycle
        run_pass(1'b0, 3, 1'b0, "gap", d, f, n, e);
        check("gap_cycle_errs", e, 0);
        check("gap_done_idx",   d, 296);
        check("gap_first_out",  f, 104);
        check("gap_n_out",      n, 128);
        check("gap_tw_en105",   tw_seen[105], 65);

        // NTT with start/mode disturbances mid-pass and in DONE
        run_pass(1'b0, 0, 1'b1, "poke", d, f, n, e);
        check("poke_cycle_errs", e, 0);
        check("poke_done_idx",   d, 233);
        check("poke_n_out",      n, 128);
        check("poke_idle_mode",  bus.pipe_mode, 0);

        // INTT pass aborted by reset after 50 enabled cycles
        bus.start = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 400 && cnt < 50; c++) begin
            #2;
            if (bus.pipe_en === 1'b1) cnt++;
            tick();
        end
        check("abort_en_reached", cnt, 50);
        #2;
        rst = 1'b1;
        #1;
        check("abort_in_ready",  bus.in_ready,  0);
        check("abort_pipe_en",   bus.pipe_en,   0);
        check("abort_pipe_mode", bus.pipe_mode, 0);
        check("abort_tw_addr",   bus.tw_addr,   64);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out_idx",   bus.out_idx,   0);
        check("abort_busy",      bus.busy,      0);
        check("abort_done",      bus.done,      0);
        tick();
        rst = 1'b0;
        tick();
        run_pass(1'b0, 0, 1'b0, "post_rst", d, f, n, e);
        check("post_rst_cycle_errs", e, 0);
        check("post_rst_done_idx",   d, 233);
        check("post_rst_first_out",  f, 104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
